// File: rtl/galapagos_bridge_pkg.sv
// Shared Galapagos bridge definitions: arbiter FSM encodings, default stream widths and helpers.
// Imported by the stream arbiter and its round-robin pick logic.
package galapagos_bridge_pkg;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StArb   = 2'd1;
  localparam logic [1:0] StGrant = 2'd2;

  localparam int unsigned GpDataWidth = 512;
  localparam int unsigned GpIdWidth   = 8;

  function automatic int unsigned gp_keep_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/gp_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after the pointer, wrapping.
module gp_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  always_comb begin
    int unsigned k;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = 32'(ptr) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = k[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/galapagos_stream_arbiter.sv
// Packet-level round-robin arbiter merging NUM_REQ Galapagos streams onto one registered output.
// Optional per-requester packet counters when GP_ARB_STATS_EN is defined.
module galapagos_stream_arbiter
  import galapagos_bridge_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned GP_DATA_WIDTH = GpDataWidth,
  parameter int unsigned GP_ID_WIDTH   = GpIdWidth
) (
  input  logic                               i_clk,
  input  logic                               i_aresetn,
  input  logic [NUM_REQ-1:0]                 i_req_TVALID,
  output logic [NUM_REQ-1:0]                 o_req_TREADY,
  input  logic [NUM_REQ*GP_DATA_WIDTH-1:0]   i_req_TDATA,
  input  logic [NUM_REQ*GP_DATA_WIDTH/8-1:0] i_req_TKEEP,
  input  logic [NUM_REQ*GP_ID_WIDTH-1:0]     i_req_TDEST,
  input  logic [NUM_REQ*GP_ID_WIDTH-1:0]     i_req_TID,
  input  logic [NUM_REQ-1:0]                 i_req_TLAST,
  output logic                               o_gp_TVALID,
  input  logic                               i_gp_TREADY,
  output logic [GP_DATA_WIDTH-1:0]           o_gp_TDATA,
  output logic [GP_DATA_WIDTH/8-1:0]         o_gp_TKEEP,
  output logic [GP_ID_WIDTH-1:0]             o_gp_TDEST,
  output logic [GP_ID_WIDTH-1:0]             o_gp_TID,
  output logic                               o_gp_TLAST,
  output logic [NUM_REQ-1:0]                 o_grant
`ifdef GP_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]              o_pkt_count
`endif
);

  localparam int unsigned KEEP_W = gp_keep_width(GP_DATA_WIDTH);
  localparam int unsigned IDX_W  = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  // Async assert, deassert synchronised to i_clk.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) rst_sync_q <= 2'b00;
    else            rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d, gidx_q, gidx_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;
  logic               slot_ready, accept, sel_last;

  gp_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req   (i_req_TVALID),
    .ptr   (ptr_q),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign slot_ready   = !o_gp_TVALID || i_gp_TREADY;
  assign o_req_TREADY = (state_q == StGrant && slot_ready) ? grant_q : '0;
  assign o_grant      = grant_q;
  assign accept       = |(i_req_TVALID & o_req_TREADY);
  assign sel_last     = i_req_TLAST[gidx_q];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    grant_d = grant_q;
    case (state_q)
      StIdle: if (|i_req_TVALID) state_d = StArb;
      StArb: begin
        if (pick_found) begin
          grant_d = pick_gnt;
          gidx_d  = pick_idx;
          state_d = StGrant;
        end else begin
          state_d = StIdle;
        end
      end
      StGrant: begin
        // Grant is released on the TLAST acceptance, not when it leaves the output slot.
        if (accept && sel_last) begin
          grant_d = '0;
          state_d = StIdle;
          ptr_d   = (gidx_q == LAST_IDX) ? '0 : gidx_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      gidx_q  <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      grant_q <= grant_d;
    end
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      o_gp_TVALID <= 1'b0;
      o_gp_TDATA  <= '0;
      o_gp_TKEEP  <= '0;
      o_gp_TDEST  <= '0;
      o_gp_TID    <= '0;
      o_gp_TLAST  <= 1'b0;
    end else if (accept) begin
      o_gp_TVALID <= 1'b1;
      o_gp_TDATA  <= i_req_TDATA[gidx_q*GP_DATA_WIDTH +: GP_DATA_WIDTH];
      o_gp_TKEEP  <= i_req_TKEEP[gidx_q*KEEP_W +: KEEP_W];
      o_gp_TDEST  <= i_req_TDEST[gidx_q*GP_ID_WIDTH +: GP_ID_WIDTH];
      o_gp_TID    <= i_req_TID[gidx_q*GP_ID_WIDTH +: GP_ID_WIDTH];
      o_gp_TLAST  <= sel_last;
    end else if (i_gp_TREADY) begin
      o_gp_TVALID <= 1'b0;
    end
  end

`ifdef GP_ARB_STATS_EN
  logic [15:0] cnt_q [NUM_REQ];

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else if (accept && sel_last) begin
      cnt_q[gidx_q] <= cnt_q[gidx_q] + 16'd1;
    end
  end

  always_comb begin
    o_pkt_count = '0;
    for (int i = 0; i < NUM_REQ; i++) o_pkt_count[i*16 +: 16] = cnt_q[i];
  end
`endif

endmodule
